// File: rtl/risc_mem_arbiter.sv
// Per-cycle arbiter sharing one single-port, 1-cycle-latency SRAM between the
// fetch port and the load/store port. The data port wins unless fetch has starved.
module risc_mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             pend_if;
  logic             pend_d;
  logic             force_if;

  // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
  always_comb begin
    force_if = if_req && (starve_cnt == CNT_MAX);
    d_gnt    = rst_n && d_req && !force_if;
    if_gnt   = rst_n && if_req && !d_gnt;
  end

  always_comb begin
    sram_ce    = if_gnt | d_gnt;
    sram_we    = d_gnt & d_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (if_gnt) begin
      sram_addr  = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      pend_if    <= 1'b0;
      pend_d     <= 1'b0;
    end else begin
      pend_d  <= d_gnt & ~d_we;
      pend_if <= if_gnt & ~if_flush;
      if (if_gnt || !if_req) begin
        starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // A flush in the return cycle also squashes the fetch already in flight.
  always_comb begin
    if_rvalid = pend_if & ~if_flush;
    d_rvalid  = pend_d;
    if_rdata  = if_rvalid ? sram_rdata : '0;
    d_rdata   = d_rvalid  ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter: a stimulus process predicts grants and
// queues expected read data; a monitor pops and compares whenever rvalid shows up.
module tb_risc_mem_arbiter;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              sram_ce, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  risc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM environment model
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              if_q[$];
  exp_t              d_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                total = 0;
  int                bad = 0;
  int                m_wait = 0;
  logic              g_if = 1'b0, g_d = 1'b0, seen_if_gnt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: responses are due exactly one cycle after the predicted grant.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
    chk("if_rvalid", 64'(if_rvalid), 64'(exp_v));
    if (exp_v) begin
      e = if_q.pop_front();
      chk("if_rdata", 64'(if_rdata), 64'(e.data));
    end else begin
      chk("if_rdata_idle", 64'(if_rdata), 64'd0);
    end
    exp_v = (d_q.size() > 0) && (d_q[0].due == cyc);
    chk("d_rvalid", 64'(d_rvalid), 64'(exp_v));
    if (exp_v) begin
      e = d_q.pop_front();
      chk("d_rdata", 64'(d_rdata), 64'(e.data));
    end else begin
      chk("d_rdata_idle", 64'(d_rdata), 64'd0);
    end
  end

  // Called just after a posedge with the cycle's inputs already driven;
  // returns just after the next posedge.
  task automatic step();
    exp_t        e;
    logic        e_d, e_if;
    logic [63:0] xa, xw;
    if (!rst_n) begin
      if_q.delete();
      d_q.delete();
      m_wait = 0;
    end else if (if_flush && if_q.size() > 0 && if_q[if_q.size()-1].due == cyc) begin
      if_q.pop_back();
    end
    @(negedge clk);
    e_d  = rst_n && d_req && !(if_req && m_wait == int'(STARVE_MAX));
    e_if = rst_n && if_req && !e_d;
    xa   = e_d ? 64'(d_addr) : (e_if ? 64'(if_addr) : 64'd0);
    xw   = e_d ? 64'(d_wdata) : 64'd0;
    chk("d_gnt", 64'(d_gnt), 64'(e_d));
    chk("if_gnt", 64'(if_gnt), 64'(e_if));
    chk("sram_ce", 64'(sram_ce), 64'(e_d || e_if));
    chk("sram_we", 64'(sram_we), 64'(e_d && d_we));
    chk("sram_addr", 64'(sram_addr), xa);
    chk("sram_wdata", 64'(sram_wdata), xw);
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_wait));
    seen_if_gnt = if_gnt;
    if (e_d && d_we) ref_mem[d_addr] = d_wdata;
    if (e_d && !d_we) begin
      e.data = ref_mem[d_addr];
      e.due  = cyc + 1;
      d_q.push_back(e);
    end
    if (e_if && !if_flush) begin
      e.data = ref_mem[if_addr];
      e.due  = cyc + 1;
      if_q.push_back(e);
    end
    if (!rst_n || e_if || !if_req) m_wait = 0;
    else if (e_d) m_wait++;
    g_if = e_if;
    g_d  = e_d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_if, first_if;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;

    // reset held with both requests active: no grants, no SRAM activity
    if_req = 1'b1; if_addr = 10'h005; d_req = 1'b1; d_addr = 10'h006;
    step();
    step();
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    step();

    // fetch of 0x010
    if_req = 1'b1; if_addr = 10'h010;
    step();
    if_req = 1'b0;
    step();
    step();

    // store then load of 0x020
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'h1234_5678;
    step();
    d_we = 1'b0; d_wdata = '0;
    step();
    d_req = 1'b0;
    step();
    step();

    // both ports saturated: D,D,D,D,IF repeating
    if_req = 1'b1; if_addr = 10'h040; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h041;
    n_if = 0; first_if = -1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (seen_if_gnt) begin
        n_if++;
        if (first_if < 0) first_if = i;
      end
    end
    chk("starve_if_count", 64'(n_if), 64'd3);
    chk("starve_first_if", 64'(first_if), 64'd4);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // flush in the return cycle, with an unaffected load alongside
    if_req = 1'b1; if_addr = 10'h050;
    step();
    if_req = 1'b0; if_flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h051;
    step();
    if_flush = 1'b0; d_req = 1'b0;
    step();
    // flush in the grant cycle
    if_req = 1'b1; if_addr = 10'h052; if_flush = 1'b1;
    step();
    if_req = 1'b0; if_flush = 1'b0;
    step();
    step();

    // load granted, then reset pulsed in the return cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h060;
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1; d_req = 1'b0;
    step();
    step();
    step();

    // randomized traffic on a small address window to provoke store/load reuse
    for (int i = 0; i < 600; i++) begin
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 10'($urandom_range(0, 31));
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 10'($urandom_range(0, 31));
        d_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 5) == 0);
      step();
    end
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
    step();
    step();
    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
